sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-master to one-slave arbiter for sram-like buses. An instruction-fetch
// master (inst_*) and a memory-stage master (data_*) share one slave port
// (out_*). At most one transaction is outstanding: a request is issued in
// IDLE (zero-cycle latency), held in ADDR until the slave accepts the
// address, and completed in DATA when the slave returns out_data_ok.
// Data wins ties between the masters.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a 4-bit starvation counter
// forces an instruction grant after STARVE_LIMIT consecutive data grants
// taken while inst_req was pending. With the macro undefined, data
// strictly outranks inst.
//
// Ports
//   clk                      sole clock, rising edge
//   rst                      asynchronous reset, active-low
//   inst_req/wr/size/addr/wdata  fetch-side request
//   inst_rdata/addr_ok/data_ok   fetch-side response
//   data_req/wr/size/addr/wdata  mem-stage request
//   data_rdata/addr_ok/data_ok   mem-stage response
//   out_req/wr/size/addr/wdata   shared-slave request
//   out_rdata/addr_ok/data_ok    shared-slave response
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic [31:0] out_rdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("sram_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
    typedef enum logic       {OWN_INST, OWN_DATA}     owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;

    logic any_req;
    logic starve_force;
    logic grant_inst;   // IDLE arbitration result
    logic issuing;      // a request is on out_* this cycle
    logic sel_inst;     // out_* sourced from the inst master

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;
    assign starve_force = (starve_q >= 4'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    assign any_req    = inst_req | data_req;
    assign grant_inst = inst_req & (~data_req | starve_force);
    assign issuing    = ((state_q == S_IDLE) & any_req) | (state_q == S_ADDR);
    // Once a transaction is in flight the owner register fixes the grant.
    assign sel_inst   = (state_q == S_IDLE) ? grant_inst : (owner_q == OWN_INST);

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_d = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = grant_inst ? OWN_INST : OWN_DATA;
                    state_d = out_addr_ok ? S_DATA : S_ADDR;
                end
`ifdef ARB_STARVE_GUARD_EN
                // A pending inst that loses arbitration is counted; the
                // counter saturates rather than wrapping back to zero.
                if (!inst_req || grant_inst) begin
                    starve_d = 4'd0;
                end else if (starve_q != 4'd15) begin
                    starve_d = starve_q + 4'd1;
                end
`endif
            end
            S_ADDR: if (out_addr_ok) state_d = S_DATA;
            S_DATA: if (out_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_DATA;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

    // Outputs are combinational so a request reaches out_* in the cycle it
    // is raised.
    // NOTE: rst gates every output directly so out_req drops the instant
    // reset asserts, without waiting for a clock edge.
    always_comb begin
        out_req      = 1'b0;
        out_wr       = 1'b0;
        out_size     = 2'b00;
        out_addr     = 32'h0;
        out_wdata    = 32'h0;
        inst_rdata   = 32'h0;
        data_rdata   = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (rst) begin
            inst_rdata = out_rdata;
            data_rdata = out_rdata;
            if (issuing) begin
                out_req      = 1'b1;
                out_wr       = sel_inst ? inst_wr    : data_wr;
                out_size     = sel_inst ? inst_size  : data_size;
                out_addr     = sel_inst ? inst_addr  : data_addr;
                out_wdata    = sel_inst ? inst_wdata : data_wdata;
                inst_addr_ok = sel_inst  & out_addr_ok;
                data_addr_ok = ~sel_inst & out_addr_ok;
            end
            if (state_q == S_DATA) begin
                inst_data_ok = (owner_q == OWN_INST) & out_data_ok;
                data_data_ok = (owner_q == OWN_DATA) & out_data_ok;
            end
        end
    end

endmodule
